// File: rtl/mem_pkg.sv
// Shared definitions for the memory access unit.
//   - FSM state enum
//   - funct3 access-size encodings
//   - default timeout and wait-counter width
//   - command payload struct and size/lane helper functions
package mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2,
        ST_ERR  = 2'd3
    } state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int unsigned TIMEOUT_DEFAULT = 15;
    localparam int unsigned CNT_W           = 8;
    localparam int unsigned DATA_W          = 32;
    localparam int unsigned BE_W            = 4;

    // Captured command presented on the memory port while in REQ.
    typedef struct packed {
        logic              we;
        logic [BE_W-1:0]   be;
        logic [DATA_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } mem_cmd_t;

    // Legal funct3 and naturally aligned offset.
    function automatic logic access_ok(input logic [2:0] f3, input logic [1:0] off);
        logic ok;
        case (f3)
            F3_B, F3_BU: ok = 1'b1;
            F3_H, F3_HU: ok = ~off[0];
            F3_W:        ok = (off == 2'b00);
            default:     ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Byte enables for a given size and byte offset.
    function automatic logic [BE_W-1:0] byte_en(input logic [2:0] f3, input logic [1:0] off);
        logic [BE_W-1:0] be;
        case (f3)
            F3_B, F3_BU: be = 4'b0001 << off;
            F3_H, F3_HU: be = 4'b0011 << {off[1], 1'b0};
            F3_W:        be = 4'b1111;
            default:     be = 4'b0000;
        endcase
        return be;
    endfunction

    // Replicate LSB-aligned store data across all lanes; byte enables pick the live one.
    function automatic logic [DATA_W-1:0] lane_data(input logic [2:0] f3, input logic [DATA_W-1:0] wd);
        logic [DATA_W-1:0] d;
        case (f3)
            F3_B, F3_BU: d = {4{wd[7:0]}};
            F3_H, F3_HU: d = {2{wd[15:0]}};
            default:     d = wd;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/load_extend.sv
// Load alignment and extension (combinational).
//   funct3 : access size/sign
//   offset : byte offset of the access within the word
//   word   : raw 32-bit word from memory
//   result : selected byte/halfword, sign- or zero-extended; full word for W
module load_extend
    import mem_pkg::*;
(
    input  logic [2:0]        funct3,
    input  logic [1:0]        offset,
    input  logic [DATA_W-1:0] word,
    output logic [DATA_W-1:0] result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Lane select
    always_comb begin
        byte_sel = word[7:0];
        case (offset)
            2'd0:    byte_sel = word[7:0];
            2'd1:    byte_sel = word[15:8];
            2'd2:    byte_sel = word[23:16];
            default: byte_sel = word[31:24];
        endcase
        half_sel = offset[1] ? word[31:16] : word[15:0];
    end

    // Extension by size/sign
    always_comb begin
        result = '0;
        case (funct3)
            F3_B:    result = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   result = {24'h0, byte_sel};
            F3_H:    result = {{16{half_sel[15]}}, half_sel};
            F3_HU:   result = {16'h0, half_sel};
            F3_W:    result = word;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Memory access unit: turns a single load/store request into a bus
// transaction with size-based byte enables, lane placement, load extension
// and a wait-state timeout.
//   clk, reset          : clock, async active-low reset
//   start, we, funct3,
//   addr, wdata         : request from the control FSM (sampled in IDLE)
//   busy, done, err     : status (done/err are one-cycle pulses)
//   rdata               : last successful load result
//   mem_req, mem_we, mem_addr, mem_be, mem_wdata : memory request port
//   mem_ack, mem_rdata  : memory response
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              we,
    input  logic [2:0]        funct3,
    input  logic [DATA_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [BE_W-1:0]   mem_be,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    mem_cmd_t          cmd_q, cmd_d;
    logic [2:0]        f3_q, f3_d;
    logic [1:0]        off_q, off_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              req_q, req_d;
    logic [DATA_W-1:0] ld_val;

    load_extend u_load_extend (
        .funct3 (f3_q),
        .offset (off_q),
        .word   (mem_rdata),
        .result (ld_val)
    );

    // State and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            cmd_q   <= '0;
            f3_q    <= '0;
            off_q   <= '0;
            rdata_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            req_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cmd_q   <= cmd_d;
            f3_q    <= f3_d;
            off_q   <= off_d;
            rdata_q <= rdata_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            req_q   <= req_d;
        end
    end

    // Next state; status flops are loaded with the values of the state being entered
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cmd_d   = cmd_q;
        f3_d    = f3_q;
        off_d   = off_q;
        rdata_d = rdata_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        err_d   = 1'b0;
        req_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    busy_d = 1'b1;
                    if (access_ok(funct3, addr[1:0])) begin
                        state_d     = ST_REQ;
                        req_d       = 1'b1;
                        cnt_d       = '0;
                        cmd_d.we    = we;
                        cmd_d.be    = byte_en(funct3, addr[1:0]);
                        cmd_d.addr  = {addr[31:2], 2'b00};
                        cmd_d.wdata = lane_data(funct3, wdata);
                        f3_d        = funct3;
                        off_d       = addr[1:0];
                    end else begin
                        state_d = ST_ERR;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                    end
                end
            end
            ST_REQ: begin
                busy_d = 1'b1;
                // Ack is checked first so an ack on the last allowed cycle still succeeds
                if (mem_ack) begin
                    if (!cmd_q.we) begin
                        rdata_d = ld_val;
                    end
                    state_d = ST_RESP;
                    done_d  = 1'b1;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_ERR;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                    cnt_d   = '0;
                end else begin
                    req_d = 1'b1;
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RESP: state_d = ST_IDLE;
            ST_ERR:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign rdata     = rdata_q;
    assign mem_req   = req_q;
    assign mem_we    = cmd_q.we;
    assign mem_addr  = cmd_q.addr;
    assign mem_be    = cmd_q.be;
    assign mem_wdata = cmd_q.wdata;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit (TIMEOUT = 4).
module tb_mem_access_unit;

    localparam int unsigned TO = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        we;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] rdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int n_chk  = 0;
    int n_fail = 0;

    // Expected per-cycle outputs from the model
    logic        e_busy, e_done, e_err, e_req, e_we;
    logic [31:0] e_rdata, e_addr, e_wdata;
    logic [3:0]  e_be;
    bit          chk_en = 1'b0;

    // Values observed on the bus during the first REQ cycle of the last access
    logic [31:0] obs_addr, obs_wdata;
    logic [3:0]  obs_be;
    logic        obs_we;
    int          done_at;

    always #5 clk = ~clk;

    mem_access_unit #(.TIMEOUT(TO)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .we        (we),
        .funct3    (funct3),
        .addr      (addr),
        .wdata     (wdata),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .rdata     (rdata),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_be    (mem_be),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---- model: plain arithmetic on sizes and offsets ----
    function automatic int size_of(input logic [2:0] f);
        case (f)
            3'd0, 3'd4: return 1;
            3'd1, 3'd5: return 2;
            3'd2:       return 4;
            default:    return 0;
        endcase
    endfunction

    function automatic logic [3:0] m_be(input int n, input logic [31:0] a);
        logic [3:0] b;
        b = 4'((1 << n) - 1);
        return b << a[1:0];
    endfunction

    function automatic logic [31:0] m_lanes(input int n, input logic [31:0] wd);
        logic [31:0] v;
        v = '0;
        for (int i = 0; i < 4; i++) v[8*i +: 8] = wd[8*(i % n) +: 8];
        return v;
    endfunction

    function automatic logic [31:0] m_load(input logic [31:0] word, input logic [2:0] f,
                                           input logic [31:0] a);
        int n;
        logic [31:0] mask, v;
        n    = size_of(f);
        mask = (n == 4) ? 32'hFFFF_FFFF : 32'((64'd1 << (8 * n)) - 64'd1);
        v    = (word >> (8 * int'(a[1:0]))) & mask;
        if ((f == 3'd0 || f == 3'd1) && v[8*n-1]) v = v | ~mask;
        return v;
    endfunction

    // Compare DUT against model on every cycle
    always @(negedge clk) begin
        if (chk_en) begin
            check("busy",  32'(busy),    32'(e_busy));
            check("done",  32'(done),    32'(e_done));
            check("err",   32'(err),     32'(e_err));
            check("req",   32'(mem_req), 32'(e_req));
            check("rdata", rdata,        e_rdata);
            if (e_req) begin
                check("mem_addr",  mem_addr,      e_addr);
                check("mem_be",    32'(mem_be),   32'(e_be));
                check("mem_we",    32'(mem_we),   32'(e_we));
                check("mem_wdata", mem_wdata,     e_wdata);
            end
        end
    end

    task automatic set_idle();
        start = 1'b0; mem_ack = 1'b0;
        e_busy = 1'b0; e_done = 1'b0; e_err = 1'b0; e_req = 1'b0;
    endtask

    // One access; returns through done_at the cycle index (start cycle = 0) of done
    task automatic run_txn(input logic w, input logic [2:0] f, input logic [31:0] a,
                           input logic [31:0] wd, input logic [31:0] rw, input int waits);
        int  n;
        int  j;
        bit  ok;
        bit  got;
        n  = size_of(f);
        ok = (n != 0) && ((a % n) == 0);
        @(posedge clk); #1;
        set_idle();
        start = 1'b1; we = w; funct3 = f; addr = a; wdata = wd;
        if (!ok) begin
            @(posedge clk); #1;
            start = 1'b0;
            e_busy = 1'b1; e_done = 1'b1; e_err = 1'b1;
            done_at = 1;
            return;
        end
        e_addr = {a[31:2], 2'b00}; e_be = m_be(n, a); e_we = w; e_wdata = m_lanes(n, wd);
        j = 0; got = 1'b0;
        forever begin
            @(posedge clk); #1;
            // Start and address changes while busy must be ignored
            start  = (j == 1);
            addr   = ~a;
            funct3 = 3'd0;
            e_busy = 1'b1; e_req = 1'b1; e_done = 1'b0; e_err = 1'b0;
            mem_ack   = (j == waits);
            mem_rdata = mem_ack ? rw : $urandom;
            if (j == 0) begin
                @(negedge clk);
                obs_addr = mem_addr; obs_be = mem_be; obs_wdata = mem_wdata; obs_we = mem_we;
            end
            if (j == waits) begin got = 1'b1; break; end
            if (j == TO - 1) break;
            j++;
        end
        @(posedge clk); #1;
        start = 1'b0; mem_ack = 1'b0; mem_rdata = $urandom;
        e_req = 1'b0; e_busy = 1'b1; e_done = 1'b1; e_err = !got;
        if (got && !w) e_rdata = m_load(rw, f, a);
        done_at = j + 2;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; start = 1'b0; we = 1'b0; funct3 = '0; addr = '0; wdata = '0;
        mem_ack = 1'b0; mem_rdata = '0;
        e_rdata = '0; e_addr = '0; e_wdata = '0; e_be = '0; e_we = 1'b0;
        set_idle();
        #2;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_req",  32'(mem_req), 32'd0);
        check("rst_be",   32'(mem_be), 32'd0);
        check("rst_addr", mem_addr, 32'd0);
        check("rst_wdata", mem_wdata, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        chk_en = 1'b1;
        @(posedge clk); #1 reset = 1'b1;

        // LW, 2 wait cycles
        run_txn(1'b0, 3'd2, 32'h100, 32'h0, 32'hDEAD_BEEF, 2);
        check("lw_done_at", 32'(done_at), 32'd4);
        check("lw_be",      32'(obs_be), 32'hF);
        check("lw_addr",    obs_addr, 32'h100);
        @(negedge clk);
        check("lw_rdata",   rdata, 32'hDEAD_BEEF);

        // LB / LBU at top byte
        run_txn(1'b0, 3'd0, 32'h103, 32'h0, 32'h80FF_1234, 0);
        check("lb_done_at", 32'(done_at), 32'd2);
        check("lb_be",      32'(obs_be), 32'b1000);
        @(negedge clk);
        check("lb_rdata",   rdata, 32'hFFFF_FF80);
        run_txn(1'b0, 3'd4, 32'h103, 32'h0, 32'h80FF_1234, 0);
        @(negedge clk);
        check("lbu_rdata",  rdata, 32'h0000_0080);

        // SH upper half; rdata must hold
        run_txn(1'b1, 3'd1, 32'h202, 32'h0000_ABCD, 32'h1111_1111, 1);
        check("sh_we",    32'(obs_we), 32'd1);
        check("sh_be",    32'(obs_be), 32'b1100);
        check("sh_wdata", obs_wdata, 32'hABCD_ABCD);
        check("sh_addr",  obs_addr, 32'h200);
        @(negedge clk);
        check("sh_rdata", rdata, 32'h0000_0080);

        // Halfword sign/zero extension
        run_txn(1'b0, 3'd1, 32'h102, 32'h0, 32'h8001_7FFF, 1);
        @(negedge clk);
        check("lh_rdata", rdata, 32'hFFFF_8001);
        run_txn(1'b0, 3'd5, 32'h100, 32'h0, 32'h8001_7FFF, 0);
        @(negedge clk);
        check("lhu_rdata", rdata, 32'h0000_7FFF);

        // Misaligned word and illegal funct3
        run_txn(1'b0, 3'd2, 32'h101, 32'h0, 32'h0, 0);
        check("mis_done_at", 32'(done_at), 32'd1);
        run_txn(1'b1, 3'd3, 32'h100, 32'h0, 32'h0, 0);
        check("ill_done_at", 32'(done_at), 32'd1);

        // Timeout, then an immediately following access whose ack lands on the last cycle
        run_txn(1'b0, 3'd2, 32'h104, 32'h0, 32'h5555_5555, 10);
        check("to_done_at", 32'(done_at), 32'd5);
        run_txn(1'b0, 3'd2, 32'h108, 32'h0, 32'h1234_5678, 3);
        check("late_done_at", 32'(done_at), 32'd5);
        @(negedge clk);
        check("late_rdata", rdata, 32'h1234_5678);

        // SB at offset 1
        run_txn(1'b1, 3'd0, 32'h001, 32'h0000_005A, 32'h0, 0);
        check("sb_be",    32'(obs_be), 32'b0010);
        check("sb_wdata", obs_wdata, 32'h5A5A_5A5A);

        // Reset in the middle of REQ
        @(posedge clk); #1;
        set_idle();
        start = 1'b1; we = 1'b1; funct3 = 3'd2; addr = 32'h300; wdata = 32'hCAFE_F00D;
        @(posedge clk); #1;
        start = 1'b0;
        e_busy = 1'b1; e_req = 1'b1;
        e_addr = 32'h300; e_be = 4'hF; e_we = 1'b1; e_wdata = 32'hCAFE_F00D;
        #2;
        reset = 1'b0;
        set_idle();
        e_rdata = '0;
        #1;
        check("arst_req",   32'(mem_req), 32'd0);
        check("arst_busy",  32'(busy), 32'd0);
        check("arst_rdata", rdata, 32'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        run_txn(1'b1, 3'd2, 32'h300, 32'hCAFE_F00D, 32'h0, 0);
        check("sw_done_at", 32'(done_at), 32'd2);
        check("sw_wdata",   obs_wdata, 32'hCAFE_F00D);

        @(posedge clk); #1;
        set_idle();
        repeat (2) @(posedge clk);
        #1 chk_en = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
